// File: rtl/sdram_ctrl_fsm_pkg.sv
// Shared state codes and small helpers for the SDRAM sequencing controller.
// The I_*/W_* encodings are the codes sdram_cmd decodes.
package sdram_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        I_NOP           = 4'd0,
        I_PRECHARGE     = 4'd1,
        I_TRP           = 4'd2,
        I_AUTO_REFRESH1 = 4'd3,
        I_TRF1          = 4'd4,
        I_AUTO_REFRESH2 = 4'd5,
        I_TRF2          = 4'd6,
        I_MRS           = 4'd7,
        I_TMRD          = 4'd8,
        I_DONE          = 4'd9
    } init_state_e;

    typedef enum logic [3:0] {
        W_IDLE   = 4'd0,
        W_ACTIVE = 4'd1,
        W_TRCD   = 4'd2,
        W_READ   = 4'd3,
        W_CL     = 4'd4,
        W_RD     = 4'd5,
        W_WRITE  = 4'd6,
        W_WD     = 4'd7,
        W_TDAL   = 4'd8,
        W_AR     = 4'd9,
        W_TRFC   = 4'd10
    } work_state_e;

    // A byte field of zero encodes the maximum burst of 512 words.
    function automatic logic [9:0] burst_len(input logic [8:0] bytes);
        return (bytes == 9'd0) ? 10'd512 : {1'b0, bytes};
    endfunction

    // True on the final cycle of a stage lasting dur cycles.
    function automatic logic stage_last(input logic [31:0] cnt, input logic [31:0] dur);
        return cnt == (dur - 32'd1);
    endfunction

endpackage

// File: rtl/sdram_ctrl_fsm_refresh_timer.sv
// Free-running auto-refresh interval counter with a sticky pending flag.
// The flag sets on each wrap and clears when the controller enters W_AR.
module sdram_ctrl_fsm_refresh_timer #(
    parameter int T_REF = 780
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic ref_pend
);

    logic [31:0] tmr_r;
    logic        wrap_s;

    assign wrap_s = en && (tmr_r == 32'(T_REF - 1));

    // Interval counter and pending flag; a clear wins over a coincident wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_r    <= 32'd0;
            ref_pend <= 1'b0;
        end else begin
            if (en) begin
                tmr_r <= wrap_s ? 32'd0 : tmr_r + 32'd1;
            end
            if (clr) begin
                ref_pend <= 1'b0;
            end else if (wrap_s) begin
                ref_pend <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_ctrl_fsm.sv
// SDRAM sequencing controller: power-up init, refresh scheduling, and
// read/write burst arbitration driving the state codes consumed by sdram_cmd.
module sdram_ctrl_fsm
    import sdram_ctrl_fsm_pkg::*;
#(
    parameter int T_POWERUP = 20000,
    parameter int T_RP      = 2,
    parameter int T_RFC     = 7,
    parameter int T_MRD     = 2,
    parameter int T_RCD     = 2,
    parameter int T_CL      = 3,
    parameter int T_DAL     = 4,
    parameter int T_REF     = 780
) (
    input  logic        clk_100m,
    input  logic        rst,
    input  logic        wr_req,
    input  logic        rd_req,
    input  logic [8:0]  sdwr_bytes,
    input  logic [8:0]  sdrd_bytes,
    output logic        wr_ack,
    output logic        rd_ack,
    output logic [3:0]  init_state,
    output logic [3:0]  work_state,
    output logic [31:0] cnt_clk,
    output logic        sys_r_wn,
    output logic        wr_data_en,
    output logic        rd_data_valid,
    output logic        wr_done,
    output logic        rd_done,
    output logic        init_done,
    output logic        busy
);

    init_state_e init_r, init_nxt_s;
    work_state_e work_r, work_nxt_s;
    logic [31:0] cnt_nxt_s;
    logic [9:0]  len_r;
    logic [31:0] len32_s;
    logic        last_wr_r;
    logic        grant_rd_s, grant_wr_s;
    logic        ref_pend_s, ref_clr_s, ref_en_s;

    assign init_state = init_r;
    assign work_state = work_r;
    assign len32_s    = {22'd0, len_r};
    assign ref_en_s   = (init_r == I_DONE);
    assign ref_clr_s  = (work_nxt_s == W_AR) && (work_r != W_AR);

    sdram_ctrl_fsm_refresh_timer #(.T_REF(T_REF)) u_refresh_timer (
        .clk      (clk_100m),
        .rst      (rst),
        .en       (ref_en_s),
        .clr      (ref_clr_s),
        .ref_pend (ref_pend_s)
    );

    // Init sequence next-state.
    always_comb begin
        init_nxt_s = init_r;
        case (init_r)
            I_NOP:           init_nxt_s = stage_last(cnt_clk, 32'(T_POWERUP)) ? I_PRECHARGE : I_NOP;
            I_PRECHARGE:     init_nxt_s = I_TRP;
            I_TRP:           init_nxt_s = stage_last(cnt_clk, 32'(T_RP)) ? I_AUTO_REFRESH1 : I_TRP;
            I_AUTO_REFRESH1: init_nxt_s = I_TRF1;
            I_TRF1:          init_nxt_s = stage_last(cnt_clk, 32'(T_RFC)) ? I_AUTO_REFRESH2 : I_TRF1;
            I_AUTO_REFRESH2: init_nxt_s = I_TRF2;
            I_TRF2:          init_nxt_s = stage_last(cnt_clk, 32'(T_RFC)) ? I_MRS : I_TRF2;
            I_MRS:           init_nxt_s = I_TMRD;
            I_TMRD:          init_nxt_s = stage_last(cnt_clk, 32'(T_MRD)) ? I_DONE : I_TMRD;
            I_DONE:          init_nxt_s = I_DONE;
            default:         init_nxt_s = I_NOP;
        endcase
    end

    // Work next-state; in idle, refresh beats requests and ties go to the type not granted last.
    always_comb begin
        work_nxt_s = work_r;
        grant_rd_s = 1'b0;
        grant_wr_s = 1'b0;
        case (work_r)
            W_IDLE: begin
                if (init_r != I_DONE) begin
                    work_nxt_s = W_IDLE;
                end else if (ref_pend_s) begin
                    work_nxt_s = W_AR;
                end else if (rd_req && (!wr_req || last_wr_r)) begin
                    grant_rd_s = 1'b1;
                    work_nxt_s = W_ACTIVE;
                end else if (wr_req) begin
                    grant_wr_s = 1'b1;
                    work_nxt_s = W_ACTIVE;
                end else begin
                    work_nxt_s = W_IDLE;
                end
            end
            W_ACTIVE: work_nxt_s = W_TRCD;
            W_TRCD: begin
                if (stage_last(cnt_clk, 32'(T_RCD))) begin
                    work_nxt_s = sys_r_wn ? W_WRITE : W_READ;
                end else begin
                    work_nxt_s = W_TRCD;
                end
            end
            W_READ:  work_nxt_s = W_CL;
            W_CL:    work_nxt_s = stage_last(cnt_clk, 32'(T_CL)) ? W_RD : W_CL;
            W_RD:    work_nxt_s = stage_last(cnt_clk, len32_s) ? W_IDLE : W_RD;
            W_WRITE: begin
                if (len_r == 10'd1) begin
                    work_nxt_s = W_TDAL;
                end else begin
                    work_nxt_s = W_WD;
                end
            end
            W_WD:    work_nxt_s = stage_last(cnt_clk, len32_s - 32'd1) ? W_TDAL : W_WD;
            W_TDAL:  work_nxt_s = stage_last(cnt_clk, 32'(T_DAL)) ? W_IDLE : W_TDAL;
            W_AR:    work_nxt_s = W_TRFC;
            W_TRFC:  work_nxt_s = stage_last(cnt_clk, 32'(T_RFC)) ? W_IDLE : W_TRFC;
            default: work_nxt_s = W_IDLE;
        endcase
    end

    // Per-state cycle counter: restarts on any state change, saturates otherwise.
    always_comb begin
        if ((init_nxt_s != init_r) || (work_nxt_s != work_r)) begin
            cnt_nxt_s = 32'd0;
        end else if (cnt_clk == 32'hFFFF_FFFF) begin
            cnt_nxt_s = cnt_clk;
        end else begin
            cnt_nxt_s = cnt_clk + 32'd1;
        end
    end

    // State, grant record and outputs, decoded from the next state so they align with it.
    always_ff @(posedge clk_100m) begin
        if (rst) begin
            init_r        <= I_NOP;
            work_r        <= W_IDLE;
            cnt_clk       <= 32'd0;
            sys_r_wn      <= 1'b1;
            last_wr_r     <= 1'b1;
            len_r         <= 10'd0;
            rd_ack        <= 1'b0;
            wr_ack        <= 1'b0;
            rd_data_valid <= 1'b0;
            rd_done       <= 1'b0;
            wr_data_en    <= 1'b0;
            wr_done       <= 1'b0;
            init_done     <= 1'b0;
            busy          <= 1'b1;
        end else begin
            init_r  <= init_nxt_s;
            work_r  <= work_nxt_s;
            cnt_clk <= cnt_nxt_s;
            if (grant_rd_s) begin
                sys_r_wn  <= 1'b0;
                last_wr_r <= 1'b0;
                len_r     <= burst_len(sdrd_bytes);
            end else if (grant_wr_s) begin
                sys_r_wn  <= 1'b1;
                last_wr_r <= 1'b1;
                len_r     <= burst_len(sdwr_bytes);
            end
            rd_ack        <= grant_rd_s;
            wr_ack        <= grant_wr_s;
            rd_data_valid <= (work_nxt_s == W_RD);
            rd_done       <= (work_nxt_s == W_RD) && stage_last(cnt_nxt_s, len32_s);
            wr_data_en    <= (work_nxt_s == W_WRITE) || (work_nxt_s == W_WD);
            wr_done       <= (work_nxt_s == W_TDAL) && stage_last(cnt_nxt_s, 32'(T_DAL));
            init_done     <= (init_nxt_s == I_DONE);
            busy          <= (init_nxt_s != I_DONE) || (work_nxt_s != W_IDLE);
        end
    end

endmodule
